// File: rtl/nonrestore_div.sv
// nonrestore_div
//   Sequential non-restoring divider. It divides a 2*WIDTH-bit dividend by a
//   WIDTH-bit divisor and produces one quotient bit per clock. It uses the
//   same start/busy handshake as the Booth multiplier.
//
// Ports
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous reset, active-high
//   x      in   2*WIDTH    dividend, sampled on the accepted start edge
//   y      in   WIDTH      divisor, sampled on the accepted start edge
//   start  in   1          request, accepted only while busy=0
//   z      out  WIDTH      quotient
//   r      out  WIDTH      remainder
//   busy   out  1          high from the cycle after accept until done
//   done   out  1          one-cycle pulse; z/r/dz/ovf are valid from here on
//   dz     out  1          divide-by-zero flag
//   ovf    out  1          quotient-overflow flag
//
// Configuration
//   DIV_SIGNED_EN  When defined, x and y are two's complement. The core
//                  divides the magnitudes, and the signs are applied in FIX.
//                  When undefined, all operands are unsigned.
//
// Handshake
//   A request is taken on any rising edge where start=1 and the FSM is idle.
//   This includes the done cycle, so a request can be accepted back to back.
//   Operands are latched only on that edge. A start while busy is ignored.
//
// Latency
//   Normal division: done follows WIDTH+1 edges after accept.
//   Divide by zero: done follows 1 edge after accept.
//   Overflow detected at accept: done follows 2 edges after accept.
module nonrestore_div #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 start,
  output logic [WIDTH-1:0]     z,
  output logic [WIDTH-1:0]     r,
  output logic                 busy,
  output logic                 done,
  output logic                 dz,
  output logic                 ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     p;        // signed partial remainder
  logic [WIDTH-1:0]   lo;       // dividend bits still to be shifted in (MSB first)
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   yd;       // divisor magnitude
  logic               ov_pend;  // high half >= divisor: quotient cannot fit
`ifdef DIV_SIGNED_EN
  logic               neg_q;
  logic               neg_r;
`endif

  // Operand magnitudes as seen by the unsigned core
  logic [2*WIDTH-1:0] xm;
  logic [WIDTH-1:0]   ym;

  always_comb begin
    xm = x;
    ym = y;
`ifdef DIV_SIGNED_EN
    if (x[2*WIDTH-1]) xm = -x;
    if (y[WIDTH-1])   ym = -y;
`endif
  end

  // One non-restoring step: shift the next dividend bit in, then subtract
  // or add the divisor depending on the sign of the current remainder.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] p_next;

  always_comb begin
    shifted = {p[WIDTH-1:0], lo[WIDTH-1]};
    p_next  = p[WIDTH] ? (shifted + {1'b0, yd}) : (shifted - {1'b0, yd});
  end

  // Final correction and sign handling. The corrected remainder lies in
  // [0, yd), so only the low WIDTH bits need to be formed.
  logic [WIDTH-1:0] rmag;
  logic [WIDTH-1:0] fix_z;
  logic [WIDTH-1:0] fix_r;
  logic             fix_ovf;

  always_comb begin
    rmag    = p[WIDTH] ? (p[WIDTH-1:0] + yd) : p[WIDTH-1:0];
    fix_z   = q;
    fix_r   = rmag;
    fix_ovf = ov_pend;
`ifdef DIV_SIGNED_EN
    if (!ov_pend) begin
      // A negative result can reach -2^(W-1); a positive one only 2^(W-1)-1.
      if (neg_q) begin
        if (q > {1'b1, {(WIDTH-1){1'b0}}}) fix_ovf = 1'b1;
        else                               fix_z   = -q;
      end else if (q > {1'b0, {(WIDTH-1){1'b1}}}) begin
        fix_ovf = 1'b1;
      end
      if (neg_r) fix_r = -rmag;
    end
`endif
    if (fix_ovf) begin
      fix_z = {WIDTH{1'b1}};
      fix_r = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      p       <= '0;
      lo      <= '0;
      q       <= '0;
      yd      <= '0;
      ov_pend <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
      z       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            dz   <= 1'b0;
            ovf  <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            yd   <= ym;
`ifdef DIV_SIGNED_EN
            neg_q <= x[2*WIDTH-1] ^ y[WIDTH-1];
            neg_r <= x[2*WIDTH-1];
`endif
            if (y == '0) begin
              // Raw low half is reported as the remainder.
              lo    <= x[WIDTH-1:0];
              state <= S_ZERO;
            end else begin
              p       <= {1'b0, xm[2*WIDTH-1:WIDTH]};
              lo      <= xm[WIDTH-1:0];
              ov_pend <= (xm[2*WIDTH-1:WIDTH] >= ym);
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (ov_pend) begin
            state <= S_FIX;
          end else begin
            p   <= p_next;
            lo  <= {lo[WIDTH-2:0], 1'b0};
            q   <= {q[WIDTH-2:0], ~p_next[WIDTH]};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          z     <= fix_z;
          r     <= fix_r;
          ovf   <= fix_ovf;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin  // S_ZERO
          z     <= {WIDTH{1'b1}};
          r     <= lo;
          dz    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
